// File: rtl/fc_tile_engine.sv
// rtl/fc_tile_engine.sv - FC layer engine: LANES signed MACs, IFM buffered on tile 0 and replayed for later tiles
// Optional feature macro: FC_RELU_EN (negative saturated outputs forced to zero)
module fc_tile_engine #(
   parameter int IFM_WIDTH   = 8,
   parameter int WGT_WIDTH   = 8,
   parameter int ACC_WIDTH   = 24,
   parameter int OUT_WIDTH   = 16,
   parameter int OUT_SHIFT   = 8,
   parameter int LANES       = 8,
   parameter int IFM_LEN_MAX = 4096,
   parameter int LEN_W       = $clog2(IFM_LEN_MAX + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [LEN_W-1:0]             ifm_len,
   input  logic [15:0]                  num_tiles,
   input  logic [IFM_WIDTH-1:0]         ifm,
   input  logic                         ifm_valid,
   output logic                         ifm_ready,
   input  logic [LANES*WGT_WIDTH-1:0]   wgt,
   input  logic                         wgt_valid,
   output logic                         wgt_ready,
   output logic [OUT_WIDTH-1:0]         ofm,
   output logic [$clog2(LANES)-1:0]     ofm_lane,
   output logic                         ofm_valid,
   input  logic                         ofm_ready,
   output logic                         busy,
   output logic                         done
);

   localparam int LW = $clog2(LANES);
   localparam int AW = $clog2(IFM_LEN_MAX);
   localparam int PW = IFM_WIDTH + WGT_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
      {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REPLAY, S_OUT, S_FIN} state_t;

   state_t                       state_q, state_d;
   logic [LEN_W-1:0]             len_q, idx_q, len_clamped;
   logic [15:0]                  ntiles_q, tile_q;
   logic [LW-1:0]                lane_q;
   logic                         pf_valid_q;
   logic [IFM_WIDTH-1:0]         pf_data_q;
   logic [IFM_WIDTH-1:0]         ifm_buf [IFM_LEN_MAX];
   logic signed [ACC_WIDTH-1:0]  acc_q [LANES];

   logic                         consume, last_elem, last_lane, last_tile;
   logic [AW-1:0]                rd_addr;
   logic [IFM_WIDTH-1:0]         mac_x;
   logic signed [PW-1:0]         prod [LANES];
   logic signed [ACC_WIDTH-1:0]  prod_ext [LANES];
   logic signed [ACC_WIDTH-1:0]  acc_shr;
   logic [OUT_WIDTH-1:0]         sat_val;

   assign len_clamped = (ifm_len > LEN_W'(IFM_LEN_MAX)) ? LEN_W'(IFM_LEN_MAX) : ifm_len;
   assign last_elem   = (idx_q == len_q - LEN_W'(1));
   assign last_lane   = (lane_q == LW'(LANES - 1));
   assign last_tile   = (tile_q == ntiles_q - 16'd1);
   assign mac_x       = (state_q == S_LOAD) ? ifm : pf_data_q;
   assign rd_addr     = idx_q[AW-1:0] + AW'(consume);
   assign ofm_lane    = lane_q;

   // Per-lane signed product of the shared element, sign-extended to accumulator width
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         prod[k]     = $signed(mac_x) * $signed(wgt[k*WGT_WIDTH +: WGT_WIDTH]);
         prod_ext[k] = ACC_WIDTH'(prod[k]);
      end
   end

   // Rescale and saturate the lane currently being presented
   always_comb begin
      acc_shr = acc_q[lane_q] >>> OUT_SHIFT;
      if (acc_shr > SAT_MAX)
         sat_val = SAT_MAX[OUT_WIDTH-1:0];
      else if (acc_shr < SAT_MIN)
         sat_val = SAT_MIN[OUT_WIDTH-1:0];
      else
         sat_val = acc_shr[OUT_WIDTH-1:0];
`ifdef FC_RELU_EN
      if (sat_val[OUT_WIDTH-1])
         sat_val = '0;
`else
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      ifm_ready = 1'b0;
      wgt_ready = 1'b0;
      ofm_valid = 1'b0;
      ofm       = '0;
      busy      = 1'b0;
      done      = 1'b0;
      consume   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start)
               state_d = (len_clamped == '0 || num_tiles == 16'd0) ? S_FIN : S_LOAD;
         end
         S_LOAD: begin
            busy      = 1'b1;
            ifm_ready = wgt_valid;
            wgt_ready = ifm_valid;
            consume   = ifm_valid && wgt_valid;
            if (consume && last_elem)
               state_d = S_OUT;
         end
         S_REPLAY: begin
            busy      = 1'b1;
            wgt_ready = pf_valid_q;
            consume   = pf_valid_q && wgt_valid;
            if (consume && last_elem)
               state_d = S_OUT;
         end
         S_OUT: begin
            busy      = 1'b1;
            ofm_valid = 1'b1;
            ofm       = sat_val;
            if (ofm_ready && last_lane)
               state_d = last_tile ? S_FIN : S_REPLAY;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counters, accumulators and prefetch-valid flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q      <= '0;
         ntiles_q   <= '0;
         tile_q     <= '0;
         idx_q      <= '0;
         lane_q     <= '0;
         pf_valid_q <= 1'b0;
         for (int k = 0; k < LANES; k++)
            acc_q[k] <= '0;
      end else begin
         pf_valid_q <= (state_q == S_REPLAY) && !(consume && last_elem);
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  len_q    <= len_clamped;
                  ntiles_q <= num_tiles;
                  tile_q   <= '0;
                  idx_q    <= '0;
                  lane_q   <= '0;
                  for (int k = 0; k < LANES; k++)
                     acc_q[k] <= '0;
               end
            end
            S_LOAD, S_REPLAY: begin
               if (consume) begin
                  idx_q <= idx_q + LEN_W'(1);
                  for (int k = 0; k < LANES; k++)
                     acc_q[k] <= acc_q[k] + prod_ext[k];
               end
            end
            S_OUT: begin
               if (ofm_ready) begin
                  lane_q <= last_lane ? '0 : lane_q + LW'(1);
                  if (last_lane) begin
                     tile_q <= tile_q + 16'd1;
                     idx_q  <= '0;
                     for (int k = 0; k < LANES; k++)
                        acc_q[k] <= '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // IFM buffer: written during tile 0, read one element ahead during replay
   always_ff @(posedge clk) begin
      if (state_q == S_LOAD && consume)
         ifm_buf[idx_q[AW-1:0]] <= ifm;
      pf_data_q <= ifm_buf[rd_addr];
   end

endmodule

// File: tb/tb_fc_tile_engine.sv
// tb/tb_fc_tile_engine.sv - directed self-checking bench for fc_tile_engine
module tb_fc_tile_engine;

   localparam int IW    = 8;
   localparam int WW    = 8;
   localparam int L     = 8;
   localparam int LMAX  = 4096;
   localparam int LEN_W = $clog2(LMAX + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  ifm_len = '0;
   logic [15:0]       num_tiles = '0;
   logic [IW-1:0]     ifm = '0;
   logic              ifm_valid = 1'b0;
   logic              ifm_ready;
   logic [L*WW-1:0]   wgt = '0;
   logic              wgt_valid = 1'b0;
   logic              wgt_ready;
   logic [15:0]       ofm;
   logic [2:0]        ofm_lane;
   logic              ofm_valid;
   logic              ofm_ready = 1'b0;
   logic              busy;
   logic              done;

   fc_tile_engine #(
      .IFM_WIDTH(IW), .WGT_WIDTH(WW), .ACC_WIDTH(24), .OUT_WIDTH(16),
      .OUT_SHIFT(0), .LANES(L), .IFM_LEN_MAX(LMAX)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ifm_len(ifm_len), .num_tiles(num_tiles),
      .ifm(ifm), .ifm_valid(ifm_valid), .ifm_ready(ifm_ready),
      .wgt(wgt), .wgt_valid(wgt_valid), .wgt_ready(wgt_ready),
      .ofm(ofm), .ofm_lane(ofm_lane), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   int hs_cnt = 0;
   int ifm_rdy_hi = 0;
   bit in_replay = 1'b0;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (ofm_valid && ofm_ready) hs_cnt++;
      if (in_replay && ifm_ready) ifm_rdy_hi++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500000");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int wval(int t, int i, int k);
      return ((t * 37 + i * 23 + k * 13) % 97) - 48;
   endfunction

   function automatic logic [L*WW-1:0] wpack(int t, int i);
      logic [L*WW-1:0] p;
      for (int k = 0; k < L; k++) p[k*WW +: WW] = 8'(wval(t, i, k));
      return p;
   endfunction

   function automatic logic [L*WW-1:0] wlane(int base, int step);
      logic [L*WW-1:0] p;
      for (int k = 0; k < L; k++) p[k*WW +: WW] = 8'(base + step * k);
      return p;
   endfunction

   function automatic longint model(longint acc);
      longint v;
      v = acc;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`ifdef FC_RELU_EN
      if (v < 0) v = 0;
`endif
      return v;
   endfunction

   task automatic do_start(input int len, input int tiles);
      start = 1'b1;
      ifm_len = LEN_W'(len);
      num_tiles = 16'(tiles);
      tick;
      start = 1'b0;
   endtask

   task automatic load_elem(input string tag, input int x, input logic [L*WW-1:0] w);
      int n;
      n = 0;
      ifm = 8'(x);
      wgt = w;
      ifm_valid = 1'b1;
      wgt_valid = 1'b1;
      #1;
      while (!(ifm_ready && wgt_ready) && n < 20) begin
         tick;
         n++;
      end
      check({tag, "_load_hs"}, n, 0);
      tick;
      ifm_valid = 1'b0;
      wgt_valid = 1'b0;
   endtask

   task automatic replay_elem(input string tag, input logic [L*WW-1:0] w);
      int n;
      bit got;
      n = 0;
      got = 1'b0;
      ifm_valid = 1'b0;
      wgt = w;
      while (!got && n < 50) begin
         wgt_valid = ($urandom_range(0, 2) != 0);
         #1;
         if (wgt_valid && wgt_ready) got = 1'b1;
         else n++;
         tick;
      end
      check({tag, "_replay_hs"}, got, 1);
      wgt_valid = 1'b0;
   endtask

   task automatic collect(input string tag, input longint exp [L], input int bp_lane);
      int n;
      ofm_ready = 1'b1;
      for (int j = 0; j < L; j++) begin
         n = 0;
         while (!ofm_valid && n < 20) begin
            tick;
            n++;
         end
         check($sformatf("%s_lane%0d", tag, j), ofm_lane, j);
         check($sformatf("%s_val%0d", tag, j), $signed(ofm), exp[j]);
         if (j == bp_lane) begin
            ofm_ready = 1'b0;
            for (int c = 0; c < 5; c++) begin
               tick;
               check($sformatf("%s_bp_valid%0d", tag, c), ofm_valid, 1);
               check($sformatf("%s_bp_lane%0d", tag, c), ofm_lane, j);
               check($sformatf("%s_bp_val%0d", tag, c), $signed(ofm), exp[j]);
            end
            ofm_ready = 1'b1;
         end
         tick;
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ifm_ready"}, ifm_ready, 0);
      check({tag, "_wgt_ready"}, wgt_ready, 0);
      check({tag, "_ofm"}, ofm, 0);
      check({tag, "_ofm_lane"}, ofm_lane, 0);
      check({tag, "_ofm_valid"}, ofm_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   initial begin
      longint exp [L];
      int xs [5];
      int d0, h0;

      repeat (3) tick;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick;

      // basic MAC: ifm 1..4, lane k weight k+1 -> 10*(k+1)
      do_start(4, 1);
      check("basic_busy", busy, 1);
      for (int i = 0; i < 4; i++) load_elem("basic", i + 1, wlane(1, 1));
      check("basic_latency", ofm_valid, 1);
      for (int k = 0; k < L; k++) exp[k] = 10 * (k + 1);
      collect("basic", exp, -1);
      check("basic_done", done, 1);
      check("basic_busy_fin", busy, 0);
      tick;
      check("basic_done_pulse", done, 0);

      // positive and negative saturation
      do_start(4, 1);
      for (int i = 0; i < 4; i++) load_elem("satp", 127, wlane(127, 0));
      for (int k = 0; k < L; k++) exp[k] = 32767;
      collect("satp", exp, -1);
      tick;
      do_start(4, 1);
      for (int i = 0; i < 4; i++) load_elem("satn", 127, wlane(-128, 0));
`ifdef FC_RELU_EN
      for (int k = 0; k < L; k++) exp[k] = 0;
`else
      for (int k = 0; k < L; k++) exp[k] = -32768;
`endif
      collect("satn", exp, -1);
      tick;

      // replay over three tiles, ignored start mid-load, backpressure, weight gaps
      xs[0] = 3; xs[1] = -7; xs[2] = 100; xs[3] = -128; xs[4] = 55;
      d0 = done_cnt;
      h0 = hs_cnt;
      do_start(5, 3);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            start = 1'b1;
            ifm_len = LEN_W'(1);
            num_tiles = 16'd0;
         end
         load_elem("rp_t0", xs[i], wpack(0, i));
         start = 1'b0;
      end
      check("rp_t0_latency", ofm_valid, 1);
      for (int k = 0; k < L; k++) begin
         exp[k] = 0;
         for (int i = 0; i < 5; i++) exp[k] += xs[i] * wval(0, i, k);
         exp[k] = model(exp[k]);
      end
      collect("rp_t0", exp, -1);
      in_replay = 1'b1;
      wgt = wpack(1, 0);
      wgt_valid = 1'b1;
      #1;
      check("rp_first_wgt_ready0", wgt_ready, 0);
      tick;
      check("rp_first_wgt_ready1", wgt_ready, 1);
      for (int t = 1; t < 3; t++) begin
         for (int i = 0; i < 5; i++) replay_elem($sformatf("rp_t%0d", t), wpack(t, i));
         check($sformatf("rp_t%0d_latency", t), ofm_valid, 1);
         for (int k = 0; k < L; k++) begin
            exp[k] = 0;
            for (int i = 0; i < 5; i++) exp[k] += xs[i] * wval(t, i, k);
            exp[k] = model(exp[k]);
         end
         collect($sformatf("rp_t%0d", t), exp, (t == 1) ? 3 : -1);
      end
      check("rp_done", done, 1);
      tick;
      in_replay = 1'b0;
      check("rp_out_count", hs_cnt - h0, 24);
      check("rp_done_count", done_cnt - d0, 1);
      check("rp_ifm_ready_hi", ifm_rdy_hi, 0);

      // zero-size starts
      h0 = hs_cnt;
      do_start(0, 2);
      check("zero_len_done", done, 1);
      check("zero_len_valid", ofm_valid, 0);
      check("zero_len_busy", busy, 0);
      tick;
      check("zero_len_done_pulse", done, 0);
      do_start(3, 0);
      check("zero_tiles_done", done, 1);
      tick;
      check("zero_out_count", hs_cnt - h0, 0);

      // reset during load, then a clean layer
      do_start(4, 1);
      load_elem("rst", 5, wlane(1, 1));
      load_elem("rst", 6, wlane(1, 1));
      ifm = 8'd7;
      ifm_valid = 1'b1;
      wgt_valid = 1'b1;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      tick;
      ifm_valid = 1'b0;
      wgt_valid = 1'b0;
      rst_n = 1'b1;
      tick;
      do_start(3, 1);
      load_elem("post", 2, wlane(-4, 1));
      load_elem("post", -3, wlane(-4, 1));
      load_elem("post", 4, wlane(-4, 1));
      for (int k = 0; k < L; k++) exp[k] = model(3 * (k - 4));
      collect("post", exp, -1);
      check("post_done", done, 1);
      tick;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fc_tile_engine.md
# fc_tile_engine

Parametrised, single-clock fully-connected layer engine: `LANES` signed MAC lanes share one input-feature element per cycle, and each lane applies its own weight. The input vector is captured into an internal buffer during the first output tile and replayed from that buffer for every later tile, so the upstream stream is read only once. Results are rescaled, saturated and serialised one lane per handshake. It sits between the IFM/weight streamers and the output writer in the accelerator's FC path.

## Interface
- `IFM_WIDTH`, 8, signed input element width
- `WGT_WIDTH`, 8, signed weight width
- `ACC_WIDTH`, 24, signed accumulator width (≥ IFM_WIDTH+WGT_WIDTH)
- `OUT_WIDTH`, 16, signed output width
- `OUT_SHIFT`, 8, arithmetic right shift applied before saturation
- `LANES`, 8, parallel output neurons per tile
- `IFM_LEN_MAX`, 4096, input buffer depth; `LEN_W` = $clog2(IFM_LEN_MAX+1)

- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — pulse; latches `ifm_len` and `num_tiles`
- `ifm_len` in LEN_W — elements per input vector
- `num_tiles` in 16 — number of output tiles (LANES outputs each)
- `ifm` in IFM_WIDTH — input element
- `ifm_valid` / `ifm_ready` in / out 1 — IFM stream handshake
- `wgt` in LANES*WGT_WIDTH — lane k weight at bits [k*WGT_WIDTH +: WGT_WIDTH]
- `wgt_valid` / `wgt_ready` in / out 1 — weight stream handshake
- `ofm` out OUT_WIDTH — output value
- `ofm_lane` out $clog2(LANES) — lane index of `ofm`
- `ofm_valid` / `ofm_ready` out / in 1 — output handshake
- `busy` out 1 — high from accepted `start` until `done`
- `done` out 1 — one-cycle pulse at end of layer

## Operation
- States: IDLE, LOAD, REPLAY, OUT, FIN.
- IDLE:
  - `start` with `ifm_len`≠0 and `num_tiles`≠0: clear accumulators, tile=0, idx=0, go to LOAD.
  - `start` with either value 0: go to FIN; no output is produced.
  - `ifm_len` > IFM_LEN_MAX is clamped to IFM_LEN_MAX.
- `start` is ignored while `busy`.
- LOAD (tile 0 only):
  - `ifm_ready` = `wgt_valid`; `wgt_ready` = `ifm_valid`.
  - A consume happens when both valids are high. On consume: buf[idx] ← ifm; acc[k] += ifm*wgt[k] (signed, wraps modulo 2^ACC_WIDTH); idx++.
  - Last element (idx = len-1): go to OUT.
- REPLAY (tiles ≥ 1):
  - `ifm_ready` = 0.
  - The buffer is read synchronously through a prefetch register. `wgt_ready` = prefetch valid.
  - On weight consume, buf[idx] is multiplied in and the next address is prefetched.
  - Last element: go to OUT.
- OUT, per lane j = 0..LANES-1:
  - v = acc[j] >>> OUT_SHIFT, saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - `ofm` = v, `ofm_lane` = j, `ofm_valid` = 1.
  - j advances only on `ofm_valid`&&`ofm_ready`.
  - After lane LANES-1 is accepted: if tile = num_tiles-1, go to FIN; otherwise tile++, idx=0, clear accumulators, go to REPLAY.
- FIN: `done`=1 for one cycle, `busy`=0, go to IDLE.
- `ofm` and `ofm_lane` hold stable while `ofm_valid`&&!`ofm_ready`.
- Reset mid-operation: all state returns to IDLE immediately. Buffer contents become don't-care, and no `done` is issued.

## Timing
- Reset values: `ifm_ready`=0, `wgt_ready`=0, `ofm`=0, `ofm_lane`=0, `ofm_valid`=0, `busy`=0, `done`=0.
- `busy` rises the cycle after `start`. LOAD ready logic is active that same cycle.
- LOAD throughput: 1 element/cycle while both valids are held high.
- REPLAY:
  - First `wgt_ready` arrives 1 cycle after entering REPLAY (buffer read latency).
  - Then 1 element/cycle with no bubbles while `wgt_valid` is held high.
- Latency: `ofm_valid` for lane 0 asserts the cycle after the last element consume.
- OUT needs at least LANES cycles per tile, one lane per accepted handshake.
- `done` pulses the cycle after the final `ofm` handshake, or 1 cycle after a zero-size `start`.

## Configuration
- `FC_RELU_EN` defined: negative saturated values are output as 0 (ReLU applied after saturation).
- `FC_RELU_EN` undefined: signed saturated values are passed through unchanged.

## Test plan
- Basic MAC (LANES=8, OUT_SHIFT=0, ifm_len=4, num_tiles=1): ifm=1,2,3,4; every wgt lane k=k+1 -> ofm lanes 0..7 = 10,20,…,80, then `done`.
- Saturation (OUT_SHIFT=0, OUT_WIDTH=16): ifm=127, wgt=127, ifm_len=4 -> 32767. With wgt=-128 -> -32768, or 0 when `FC_RELU_EN` is defined.
- Replay (num_tiles=3, ifm_len=5): `ifm_ready` is never high after tile 0. Each tile's outputs match a golden model computed from the tile-0 ifm. Exactly 24 outputs, then one `done`.
- Backpressure: hold `ofm_ready`=0 for 5 cycles on lane 3 -> `ofm` and `ofm_lane` are stable and lane 4 is not skipped. Random `wgt_valid` gaps in REPLAY give no lost or duplicated elements.
- Zero size and `start` while busy: ifm_len=0 -> `done` 1 cycle later with no `ofm_valid`. A second `start` mid-tile is ignored.
- Reset mid-LOAD: assert `rst_n`=0 at element 2 -> all outputs at reset values. A new `start` then completes correctly.
